// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Imported by md_unit, the ID-stage decoder and the hazard unit so that all
// three agree on the md_op encoding and the default operation latencies.
package md_defs;

  // Operation codes carried on md_op from ID/EX. Codes 7 and MD_NONE are no-ops.
  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MULT    = 3'd1,
    MULTU   = 3'd2,
    DIV     = 3'd3,
    DIVU    = 3'd4,
    MTHI    = 3'd5,
    MTLO    = 3'd6
  } md_op_e;

  // Unit state: IDLE accepts a new op, RUN counts down an in-flight op.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Default busy lengths in cycles.
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // True for ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit in the EX stage, owner of the HI/LO registers.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   synchronous, active-high reset
//   start    in   1   one-cycle strobe: md_op holds a multiply/divide op
//   md_op    in   3   MULT/MULTU/DIV/DIVU/MTHI/MTLO (others: no-op)
//   rs_data  in   32  forwarded rs operand
//   rt_data  in   32  forwarded rt operand
//   busy     out  1   high while a multiply or divide is in flight
//   hi       out  32  committed HI register
//   lo       out  32  committed LO register
//
// Operation: the result of MULT/MULTU/DIV/DIVU is computed from the operands
// on the accepting edge and parked in a pending register; it is committed to
// hi/lo only when the down-counter expires, so hi/lo never show it early.
// The start/op handshake is a plain strobe: start is honoured only in IDLE
// and dropped without effect while busy is high.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       pend_hi;
  logic [31:0]       pend_lo;
  logic              pend_wr;

  // Combinational result of the op currently presented on the inputs.
  logic [63:0]        prod_u;
  logic signed [63:0] prod_s;
  logic [31:0]        dvd;
  logic [31:0]        dvs;
  logic [31:0]        dvs_safe;
  logic [31:0]        quo;
  logic [31:0]        rem;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_wr;

  always_comb begin
    prod_u   = {32'b0, rs_data} * {32'b0, rt_data};
    prod_s   = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    // Signed divide works on magnitudes; signs are restored afterwards so
    // 0x80000000 / -1 wraps to 0x80000000 with no special case.
    dvd      = (md_op == DIV && rs_data[31]) ? -rs_data : rs_data;
    dvs      = (md_op == DIV && rt_data[31]) ? -rt_data : rt_data;
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    quo      = dvd / dvs_safe;
    rem      = dvd % dvs_safe;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_wr   = 1'b1;
    case (md_op)
      MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      DIV: begin
        res_lo = (rs_data[31] ^ rt_data[31]) ? -quo : quo;
        res_hi = rs_data[31] ? -rem : rem;
        res_wr = (rt_data != 32'd0);
      end
      DIVU: begin
        res_lo = quo;
        res_hi = rem;
        res_wr = (rt_data != 32'd0);
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_long_op(md_op)) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_wr <= res_wr;
              cnt     <= (md_op == DIV || md_op == DIVU) ? CNT_W'(DIV_CYCLES)
                                                         : CNT_W'(MULT_CYCLES);
              state   <= RUN;
            end else if (md_op == MTHI) begin
              hi <= rs_data;
            end else if (md_op == MTLO) begin
              lo <= rs_data;
            end
          end
        end
        RUN: begin
          // Leaving at cnt==1 means the counter never wraps.
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a reference model pushes the expected {hi,lo} and busy
// length for every multiply/divide when it is issued; a monitor pops and
// compares them when busy falls.
module tb_md_unit;
  import md_defs::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] len_q[$];
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;
  int          run_len = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: 64-bit arithmetic, independent of the RTL formulation.
  task automatic model_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = {mdl_hi, mdl_lo};
    case (op)
      MULT:  res = 64'(sa * sb);
      MULTU: res = 64'(ua * ub);
      DIV:   if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
             end
      DIVU:  if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
      default: ;
    endcase
    if (op == MULT || op == MULTU || op == DIV || op == DIVU) begin
      exp_q.push_back(res);
      len_q.push_back((op == DIV || op == DIVU) ? 32'd10 : 32'd5);
      mdl_hi = res[63:32];
      mdl_lo = res[31:0];
    end else if (op == MTHI) begin
      mdl_hi = a;
    end else if (op == MTLO) begin
      mdl_lo = a;
    end
  endtask

  // Driver: start is high across exactly one rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    model_push(op, a, b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    check_eq("timeout_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor / scoreboard: one completion per falling edge of busy.
  always @(negedge clk) begin
    if (busy) begin
      run_len++;
    end else if (run_len != 0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 64'(run_len), 64'd0);
      end else begin
        check_eq("busy_len", 64'(run_len), 64'(len_q.pop_front()));
        check_eq("hilo", {hi, lo}, exp_q.pop_front());
      end
      run_len = 0;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; rs_data = 32'd0; rt_data = 32'd0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_hilo", {hi, lo}, 64'd0);

    // 1, 2: signed / unsigned multiply
    issue(MULT, 32'hFFFFFFFF, 32'h00000002);
    wait_idle();
    check_eq("t1_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    issue(MULTU, 32'hFFFFFFFF, 32'h00000002);
    wait_idle();
    check_eq("t2_multu", {hi, lo}, 64'h00000001_FFFFFFFE);

    // 3: signed divide and overflow wrap
    issue(DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_idle();
    check_eq("t3_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    check_eq("t3_div_ovf", {hi, lo}, 64'h00000000_80000000);

    // 4: divide by zero leaves hi/lo alone
    issue(MTHI, 32'hAAAA0000, 32'd0);
    issue(MTLO, 32'h0000BBBB, 32'd0);
    issue(DIVU, 32'h12345678, 32'd0);
    wait_idle();
    check_eq("t4_div0", {hi, lo}, 64'hAAAA0000_0000BBBB);

    // 5: MTHI is immediate; MTLO during RUN is ignored
    issue(MTHI, 32'h12345678, 32'd0);
    check_eq("t5_mthi", 64'(hi), 64'h12345678);
    check_eq("t5_mthi_busy", 64'(busy), 64'd0);
    issue(MULT, 32'h00000007, 32'hFFFFFFFD);
    @(negedge clk);
    start = 1'b1; md_op = MTLO; rs_data = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    wait_idle();
    check_eq("t5_mtlo_ignored", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    // 6: reset in busy cycle 3 aborts; then a fresh multiply
    issue(DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    len_q.delete();
    exp_q.push_back(64'd0);
    len_q.push_back(32'd3);
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_abort_busy", 64'(busy), 64'd0);
    check_eq("t6_abort_hilo", {hi, lo}, 64'd0);
    issue(MULT, 32'd3, 32'd4);
    wait_idle();
    check_eq("t6_mult_lo", 64'(lo), 64'd12);

    // Random mix
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(1, 4));
      issue(op, $urandom, (i == 5) ? 32'd0 : 32'($urandom_range(0, 32'hFFFF)));
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
